// File: rtl/digits_to_value.sv
// digits_to_value: collects NDIG octal digits (MSD first) over a valid/ready
// handshake and reassembles them into a VW-bit binary value.
module digits_to_value #(
    parameter int NDIG = 2,
    parameter int VW   = 3 * NDIG
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          newframe,
    input  logic [3:0]    digit_in,
    input  logic          digit_valid,
    output logic          digit_ready,
    output logic [VW-1:0] value_out,
    output logic          value_valid,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, COLLECT, OUT, ERR} state_t;
    localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [VW-1:0] acc_q, acc_d, acc_nx, val_q, val_d;
    logic          err_q, err_d, rdy_q, rdy_d, vv_q, vv_d;
    logic          take;

    always_comb begin
        // newframe outranks a same-cycle handshake, so the digit is dropped
        take    = digit_valid && rdy_q && !newframe;
        acc_nx  = (acc_q << 3) | VW'(digit_in[2:0]);
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        val_d   = val_q;
        err_d   = err_q;
        if (newframe) begin
            state_d = COLLECT;
            cnt_d   = '0;
            acc_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                COLLECT: if (take) begin
                    if (digit_in[3]) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        acc_d   = '0;
                    end else if (cnt_q == CW'(NDIG - 1)) begin
                        state_d = OUT;
                        val_d   = acc_nx;
                        cnt_d   = '0;
                        acc_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        acc_d = acc_nx;
                    end
                end
                OUT:     state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
        rdy_d = state_d == COLLECT;
        vv_d  = state_d == OUT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            val_q   <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
            vv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            val_q   <= val_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
            vv_q    <= vv_d;
        end
    end

    assign digit_ready = rdy_q;
    assign value_out   = val_q;
    assign value_valid = vv_q;
    assign err         = err_q;
endmodule
